// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decoder-side bus of pc_sequencer (Start/Stall/Jen/Taken/Target/DoneIn in; Prog_ctr/FirstCyc/Commit/Busy/Ack/Wrapped/CycleCnt out)
interface pc_sequencer_if #(parameter int PW = 10);
  logic Start;
  logic Stall;
  logic Jen;
  logic Taken;
  logic [PW-1:0] Target;
  logic DoneIn;
  logic [PW-1:0] Prog_ctr;
  logic FirstCyc;
  logic Commit;
  logic Busy;
  logic Ack;
  logic Wrapped;
  logic [15:0] CycleCnt;
  modport master (
    output Start, Stall, Jen, Taken, Target, DoneIn,
    input  Prog_ctr, FirstCyc, Commit, Busy, Ack, Wrapped, CycleCnt
  );
  modport slave (
    input  Start, Stall, Jen, Taken, Target, DoneIn,
    output Prog_ctr, FirstCyc, Commit, Busy, Ack, Wrapped, CycleCnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC/stall/branch/halt sequencer; Clk, Reset (sync, active-high), bus = pc_sequencer_if.slave
module pc_sequencer #(
  parameter int PW = 10,
  parameter int STALL_CYCLES = 1
) (
  input logic Clk,
  input logic Reset,
  pc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, HALT} state_t;
  localparam bit HOLDS = STALL_CYCLES > 0;
  localparam logic [2:0] HOLD_INIT = 3'(HOLDS ? STALL_CYCLES - 1 : 0);
  state_t state;
  logic [2:0] cnt;
  logic [PW-1:0] pc;
  logic [PW:0] pc_inc;
  logic [15:0] cyc;
  logic wrapped, busy, ack, commit, take;
  always_comb begin
    pc_inc = {1'b0, pc} + (PW+1)'(1);
    take = bus.Jen & bus.Taken;
    commit = (state == RUN) ? !bus.DoneIn && !(bus.Stall && HOLDS) : (state == HOLD) && (cnt == 3'd0);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      pc <= '0;
      cnt <= '0;
      wrapped <= 1'b0;
      cyc <= '0;
      busy <= 1'b0;
      ack <= 1'b0;
    end else begin
      if (busy && cyc != 16'hFFFF) cyc <= cyc + 16'd1;
      if (commit) begin
        pc <= take ? bus.Target : pc_inc[PW-1:0];
        if (!take && pc_inc[PW]) wrapped <= 1'b1;
      end
      case (state)
        IDLE, HALT: if (bus.Start) begin
          state <= RUN;
          pc <= '0;
          cyc <= '0;
          wrapped <= 1'b0;
          busy <= 1'b1;
          ack <= 1'b0;
        end
        RUN: if (bus.DoneIn) begin
          state <= HALT;
          busy <= 1'b0;
          ack <= 1'b1;
        end else if (bus.Stall && HOLDS) begin
          state <= HOLD;
          cnt <= HOLD_INIT;
        end
        HOLD: if (cnt != 3'd0) cnt <= cnt - 3'd1;
              else state <= RUN;
      endcase
    end
  end
  assign bus.Prog_ctr = pc;
  assign bus.FirstCyc = state == RUN;
  assign bus.Commit = commit;
  assign bus.Busy = busy;
  assign bus.Ack = ack;
  assign bus.Wrapped = wrapped;
  assign bus.CycleCnt = cyc;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: two sequencers (PW=10/STALL=2 and PW=4/STALL=0) on shared stimulus vs an instruction-level model
module tb_pc_sequencer;
  logic clk;
  logic i_rst, i_start, i_stall, i_jen, i_taken, i_done;
  logic [9:0] i_tgt;
  int errs = 0;
  int checks = 0;
  int pw [2] = '{10, 4};
  int sc [2] = '{2, 0};
  int m_mode [2];
  int m_pc [2];
  int m_age [2];
  int m_wr [2];
  int m_cyc [2];
  logic [15:0] g_pc [2];
  logic g_first [2];
  logic g_commit [2];
  logic g_busy [2];
  logic g_ack [2];
  logic g_wr [2];
  logic [15:0] g_cyc [2];
  pc_sequencer_if #(.PW(10)) ia ();
  pc_sequencer_if #(.PW(4)) ib ();
  pc_sequencer #(.PW(10), .STALL_CYCLES(2)) u_a (.Clk(clk), .Reset(i_rst), .bus(ia));
  pc_sequencer #(.PW(4), .STALL_CYCLES(0)) u_b (.Clk(clk), .Reset(i_rst), .bus(ib));
  assign ia.Start = i_start;
  assign ia.Stall = i_stall;
  assign ia.Jen = i_jen;
  assign ia.Taken = i_taken;
  assign ia.Target = i_tgt;
  assign ia.DoneIn = i_done;
  assign ib.Start = i_start;
  assign ib.Stall = i_stall;
  assign ib.Jen = i_jen;
  assign ib.Taken = i_taken;
  assign ib.Target = i_tgt[3:0];
  assign ib.DoneIn = i_done;
  assign g_pc[0] = 16'(ia.Prog_ctr);
  assign g_pc[1] = 16'(ib.Prog_ctr);
  assign g_first[0] = ia.FirstCyc;
  assign g_first[1] = ib.FirstCyc;
  assign g_commit[0] = ia.Commit;
  assign g_commit[1] = ib.Commit;
  assign g_busy[0] = ia.Busy;
  assign g_busy[1] = ib.Busy;
  assign g_ack[0] = ia.Ack;
  assign g_ack[1] = ib.Ack;
  assign g_wr[0] = ia.Wrapped;
  assign g_wr[1] = ib.Wrapped;
  assign g_cyc[0] = ia.CycleCnt;
  assign g_cyc[1] = ib.CycleCnt;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit ex_commit(int k);
    if (m_mode[k] != 1) return 1'b0;
    if (m_age[k] == 0) return !i_done && !(i_stall && sc[k] > 0);
    return m_age[k] == sc[k];
  endfunction
  task automatic advance(int k);
    bit c;
    int mod;
    c = ex_commit(k);
    mod = 1 << pw[k];
    if (i_rst) begin
      m_mode[k] = 0; m_pc[k] = 0; m_age[k] = 0; m_wr[k] = 0; m_cyc[k] = 0;
    end else if (m_mode[k] != 1) begin
      if (i_start) begin
        m_mode[k] = 1; m_pc[k] = 0; m_age[k] = 0; m_wr[k] = 0; m_cyc[k] = 0;
      end
    end else begin
      if (m_cyc[k] < 65535) m_cyc[k]++;
      if (m_age[k] == 0 && i_done) m_mode[k] = 2;
      else if (c) begin
        if (i_jen && i_taken) m_pc[k] = int'(i_tgt) % mod;
        else begin
          if (m_pc[k] == mod - 1) m_wr[k] = 1;
          m_pc[k] = (m_pc[k] + 1) % mod;
        end
        m_age[k] = 0;
      end else m_age[k]++;
    end
  endtask
  task automatic step(input bit st, input bit sl, input bit j, input bit t, input logic [9:0] tg, input bit d, input bit r);
    i_start = st; i_stall = sl; i_jen = j; i_taken = t; i_tgt = tg; i_done = d; i_rst = r;
    #2;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d.pc", k), int'(g_pc[k]), m_pc[k]);
      check($sformatf("u%0d.first", k), int'(g_first[k]), int'(m_mode[k] == 1 && m_age[k] == 0));
      check($sformatf("u%0d.commit", k), int'(g_commit[k]), int'(ex_commit(k)));
      check($sformatf("u%0d.busy", k), int'(g_busy[k]), int'(m_mode[k] == 1));
      check($sformatf("u%0d.ack", k), int'(g_ack[k]), int'(m_mode[k] == 2));
      check($sformatf("u%0d.wrapped", k), int'(g_wr[k]), m_wr[k]);
      check($sformatf("u%0d.cyc", k), int'(g_cyc[k]), m_cyc[k]);
      advance(k);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    i_start = 0; i_stall = 0; i_jen = 0; i_taken = 0; i_tgt = '0; i_done = 0; i_rst = 1;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_pc[k] = 0; m_age[k] = 0; m_wr[k] = 0; m_cyc[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    step(0, 0, 0, 0, 10'd0, 0, 1);
    step(0, 1, 1, 1, 10'h3ff, 1, 0);
    step(1, 0, 0, 0, 10'd0, 0, 0);
    repeat (7) step(0, 0, 0, 0, 10'd0, 0, 0);
    step(0, 0, 1, 1, 10'h2a, 0, 0);
    step(0, 0, 1, 0, 10'h15, 0, 0);
    step(1, 0, 0, 0, 10'd0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 10'd0, 0, 0);
    repeat (20) step(0, 0, 0, 0, 10'd0, 0, 0);
    step(0, 1, 0, 0, 10'd0, 1, 0);
    repeat (3) step(0, 1, 1, 1, 10'h3ff, 0, 0);
    step(1, 0, 0, 0, 10'd0, 0, 0);
    step(0, 0, 0, 0, 10'd0, 0, 0);
    repeat (2) step(0, 1, 0, 0, 10'd0, 0, 0);
    step(0, 1, 0, 0, 10'd0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 10'd0, 0, 0);
    for (int n = 0; n < 4000; n++)
      step($urandom % 20 == 0, $urandom % 3 == 0, $urandom % 4 == 0, 1'($urandom),
           10'($urandom), $urandom % 25 == 0, $urandom % 200 == 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
